// File: rtl/blink_pkg.sv
// Shared types and constants for the LED blink/pulse generator.
package blink_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        ON    = 2'b01,
        BLINK = 2'b10,
        PULSE = 2'b11
    } mode_e;

    localparam int CNT_W_DEF    = 26;
    localparam int HALF_SEC_50M = 25_000_000;

endpackage

// File: rtl/blink_channel.sv
// One LED channel: OFF/ON/BLINK/PULSE with a shared half-period counter.
module blink_channel
    import blink_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] half_period,
    input  logic             trig,
    output logic             led,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hp_m1;
    mode_e            mode_in;
    mode_e            mode_q, mode_d;
    logic             trig_q, trig_d;
    logic             led_q, led_d;
    logic             busy_q, busy_d;
    logic             wrap;
    logic             rise;

    always_comb begin
        mode_in = mode_e'(mode);
        hp_m1   = (half_period == '0) ? '0 : half_period - CNT_W'(1);
        // >= rather than == so a shrinking half-period never overruns
        wrap    = (cnt_q >= hp_m1);
        rise    = trig & ~trig_q;

        cnt_d   = cnt_q;
        led_d   = led_q;
        busy_d  = busy_q;
        mode_d  = mode_in;
        trig_d  = trig;

        if (mode_in != mode_q) begin
            cnt_d  = '0;
            busy_d = 1'b0;
            led_d  = (mode_in == ON) || (mode_in == BLINK);
        end else begin
            unique case (mode_in)
                OFF: begin
                    cnt_d  = '0;
                    led_d  = 1'b0;
                    busy_d = 1'b0;
                end
                ON: begin
                    cnt_d  = '0;
                    led_d  = 1'b1;
                    busy_d = 1'b0;
                end
                BLINK: begin
                    busy_d = 1'b0;
                    if (wrap) begin
                        cnt_d = '0;
                        led_d = ~led_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (rise) begin
                        cnt_d  = '0;
                        led_d  = 1'b1;
                        busy_d = 1'b1;
                    end else if (busy_q) begin
                        if (wrap) begin
                            cnt_d  = '0;
                            led_d  = 1'b0;
                            busy_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                        led_d = 1'b0;
                    end
                end
                default: begin
                    cnt_d  = '0;
                    led_d  = 1'b0;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            mode_q <= OFF;
            trig_q <= 1'b0;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            trig_q <= trig_d;
            led_q  <= led_d;
            busy_q <= busy_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;

endmodule

// File: rtl/blink_gen.sv
// Array of independent LED blink/pulse channels.
module blink_gen
    import blink_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*N_CH-1:0]     mode,
    input  logic [CNT_W*N_CH-1:0] half_period,
    input  logic [N_CH-1:0]       trig,
    output logic [N_CH-1:0]       led,
    output logic [N_CH-1:0]       busy
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        blink_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .mode        (mode[2*i +: 2]),
            .half_period (half_period[CNT_W*i +: CNT_W]),
            .trig        (trig[i]),
            .led         (led[i]),
            .busy        (busy[i])
        );
    end

endmodule

// File: tb/tb_blink_gen.sv
// Directed scoreboard bench for blink_gen.
module tb_blink_gen;
    import blink_pkg::*;

    localparam int N     = 4;
    localparam int CW    = 26;

    typedef logic [N-1:0] vec_t;

    typedef struct {
        string tag;
        vec_t  mask;
        vec_t  led;
        vec_t  busy;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [2*N-1:0]   mode;
    logic [CW*N-1:0]  half_period;
    vec_t             trig;
    vec_t             led;
    vec_t             busy;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    blink_gen #(
        .N_CH  (N),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .half_period (half_period),
        .trig        (trig),
        .led         (led),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t bv(int ch, bit v);
        vec_t r;
        r     = '0;
        r[ch] = v;
        return r;
    endfunction

    task automatic set_mode(int ch, mode_e m);
        mode[2*ch +: 2] = m;
    endtask

    task automatic set_hp(int ch, int v);
        half_period[CW*ch +: CW] = CW'(v);
    endtask

    task automatic push(string tag, vec_t m, vec_t l, vec_t b);
        exp_t e;
        e.tag  = tag;
        e.mask = m;
        e.led  = l;
        e.busy = b;
        sb.push_back(e);
    endtask

    task automatic chk(string tag, vec_t obs, vec_t exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".led"}, led & e.mask, e.led & e.mask);
            chk({e.tag, ".busy"}, busy & e.mask, e.busy & e.mask);
        end
    endtask

    initial begin
        vec_t all;
        vec_t l;
        all         = '1;
        rst         = 1'b1;
        mode        = '0;
        half_period = '0;
        trig        = '0;

        for (int k = 0; k < 5; k++) begin
            push("rst", all, '0, '0);
            tick();
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push("idle", all, '0, '0);
            tick();
        end

        // ch0 BLINK, period 8, high first
        set_mode(0, BLINK);
        set_hp(0, 4);
        for (int k = 0; k < 20; k++) begin
            push("blink4", bv(0, 1), bv(0, ((k / 4) % 2) == 0), '0);
            tick();
        end
        set_mode(0, OFF);
        push("blink_off", bv(0, 1), '0, '0);
        tick();

        // ch1 PULSE hp=5
        set_mode(1, PULSE);
        set_hp(1, 5);
        push("pulse_entry", bv(1, 1), '0, '0);
        tick();
        push("pulse_idle", bv(1, 1), '0, '0);
        tick();
        for (int k = 0; k < 8; k++) begin
            trig[1] = (k == 0);
            push("pulse5", bv(1, 1), bv(1, k < 5), bv(1, k < 5));
            tick();
        end
        for (int k = 0; k < 11; k++) begin
            trig[1] = (k == 0) || (k == 3);
            push("retrig", bv(1, 1), bv(1, k < 8), bv(1, k < 8));
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            trig[1] = 1'b1;
            push("held", bv(1, 1), bv(1, k < 5), bv(1, k < 5));
            tick();
        end
        trig[1] = 1'b0;
        push("held_rel", bv(1, 1), '0, '0);
        tick();

        // ch2 BLINK, half-period shrinks mid-count
        set_mode(2, BLINK);
        set_hp(2, 100);
        for (int k = 0; k <= 50; k++) begin
            push("hp100", bv(2, 1), bv(2, 1), '0);
            tick();
        end
        set_hp(2, 10);
        for (int j = 0; j < 25; j++) begin
            push("hp_shrink", bv(2, 1), bv(2, ((j / 10) % 2) == 1), '0);
            tick();
        end
        set_mode(2, ON);
        for (int k = 0; k < 2; k++) begin
            push("on", bv(2, 1), bv(2, 1), '0);
            tick();
        end

        // ch3 half_period = 0
        set_mode(3, BLINK);
        set_hp(3, 0);
        for (int k = 0; k < 8; k++) begin
            push("blink_hp0", bv(3, 1), bv(3, (k % 2) == 0), '0);
            tick();
        end
        set_mode(3, PULSE);
        push("pulse_hp0_entry", bv(3, 1), '0, '0);
        tick();
        for (int k = 0; k < 6; k++) begin
            trig[3] = ((k % 2) == 0);
            push("pulse_hp0", bv(3, 1), bv(3, (k % 2) == 0),
                 bv(3, (k % 2) == 0));
            tick();
        end
        trig[3] = 1'b0;

        // reset mid-pulse, then re-entry from OFF
        set_mode(0, BLINK);
        set_hp(0, 2);
        trig[1] = 1'b1;
        push("pre_rst", bv(1, 1), bv(1, 1), bv(1, 1));
        tick();
        trig[1] = 1'b0;
        push("pre_rst2", bv(1, 1), bv(1, 1), bv(1, 1));
        tick();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push("mid_rst", all, '0, '0);
            tick();
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            l = bv(0, ((k / 2) % 2) == 0) | bv(2, 1);
            push("post_rst", all, l, '0);
            tick();
        end

        n_tot++;
        assert (sb.size() == 0) n_pass++;
        else $error("FAIL sb_drain observed=%0d expected=0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
